// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and flag-type definitions for the word-wide ALU.
package alu_pkg;

   localparam logic [2:0] OP_AND      = 3'b000;
   localparam logic [2:0] OP_NOT      = 3'b001;
   localparam logic [2:0] OP_OR       = 3'b010;
   localparam logic [2:0] OP_XOR      = 3'b011;
   localparam logic [2:0] OP_ADD      = 3'b100;
   localparam logic [2:0] OP_SUB      = 3'b101;
   localparam logic [2:0] OP_TRANSFER = 3'b110;
   localparam logic [2:0] OP_TEST     = 3'b111;

   localparam int FLAG_Z = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef logic [3:0] flags_t;

endpackage

// File: rtl/alu_word_core.sv
// Combinational word ALU: result, candidate flags and which of C/V the op may update.
module alu_word_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       select,
   input  logic             cin,
   output logic [WIDTH-1:0] result,
   output logic             z,
   output logic             n,
   output logic             c,
   output logic             v,
   output logic             c_upd,
   output logic             v_upd
);

   logic             is_sub;
   logic             is_arith;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] flag_src;
   logic [WIDTH:0]   sum;

   always_comb begin
      is_sub   = (select == OP_SUB) || (select == OP_TEST);
      is_arith = is_sub || (select == OP_ADD);
      b_eff    = is_sub ? ~b : b;
      sum      = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};

      case (select)
         OP_AND:  result = a & b;
         OP_NOT:  result = ~a;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_ADD:  result = sum[WIDTH-1:0];
         OP_SUB:  result = sum[WIDTH-1:0];
         default: result = a;
      endcase

      // TEST reports on the difference while passing a through unchanged
      flag_src = (select == OP_TEST) ? sum[WIDTH-1:0] : result;
      z        = (flag_src == '0);
      n        = flag_src[WIDTH-1];
      c        = sum[WIDTH];
      v        = is_arith && (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      c_upd    = is_arith;
      v_upd    = (select != OP_TRANSFER);
   end

endmodule

// File: rtl/alu_word_seq.sv
// Word ALU with a single registered result stage (valid/ready) and a persistent ZNCV flag register.
module alu_word_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       select,
   input  logic             chain,
   input  logic             flags_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);

   logic             accept;
   logic             cin;
   logic [WIDTH-1:0] core_result;
   logic             core_z, core_n, core_c, core_v, core_c_upd, core_v_upd;
   logic             vld_p1;
   logic [WIDTH-1:0] result_p1;
   flags_t           flags_p1;
   flags_t           flags_nxt;

   assign in_ready = !vld_p1 || out_ready;
   assign accept   = in_valid && in_ready;

   always_comb begin
      // chain borrows the carry left by the previously accepted op
      cin = chain ? flags_p1[FLAG_C] : ((select == OP_SUB) || (select == OP_TEST));

      flags_nxt         = flags_p1;
      flags_nxt[FLAG_Z] = core_z;
      flags_nxt[FLAG_N] = core_n;
      if (core_c_upd) flags_nxt[FLAG_C] = core_c;
      if (core_v_upd) flags_nxt[FLAG_V] = core_v;
   end

   alu_word_core #(.WIDTH(WIDTH)) u_core (
      .a      (a),
      .b      (b),
      .select (select),
      .cin    (cin),
      .result (core_result),
      .z      (core_z),
      .n      (core_n),
      .c      (core_c),
      .v      (core_v),
      .c_upd  (core_c_upd),
      .v_upd  (core_v_upd)
   );

   // Stage p1: registered result and its valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1    <= 1'b0;
         result_p1 <= '0;
      end else if (accept) begin
         vld_p1    <= 1'b1;
         result_p1 <= core_result;
      end else if (out_ready) begin
         vld_p1    <= 1'b0;
      end
   end

   // An accepted op's update takes priority over a coincident clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_p1 <= '0;
      end else if (accept) begin
         flags_p1 <= flags_nxt;
      end else if (flags_clr) begin
         flags_p1 <= '0;
      end
   end

   assign out_valid = vld_p1;
   assign result    = result_p1;
   assign flags     = flags_p1;

endmodule

// File: tb/tb_alu_word_seq.sv
// Self-checking bench for alu_word_seq: directed scenarios plus randomized traffic against a reference model.
module tb_alu_word_seq;

   localparam int W = 8;
   localparam logic [2:0] AND_OP = 3'd0, NOT_OP = 3'd1, OR_OP = 3'd2, XOR_OP = 3'd3;
   localparam logic [2:0] ADD_OP = 3'd4, SUB_OP = 3'd5, TRF_OP = 3'd6, TST_OP = 3'd7;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [2:0]   select = '0;
   logic         chain = 1'b0;
   logic         flags_clr = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] result;
   logic [3:0]   flags;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   alu_word_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .select    (select),
      .chain     (chain),
      .flags_clr (flags_clr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] op, input logic [W-1:0] da,
                        input logic [W-1:0] db, input logic ch, input logic clr);
      in_valid  = v;
      select    = op;
      a         = da;
      b         = db;
      chain     = ch;
      flags_clr = clr;
   endtask

   // Reference: integer arithmetic with signed range checks for V
   function automatic void ref_op(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                  input logic [2:0] op, input logic ch, input logic [3:0] fin,
                                  output logic [W-1:0] res, output logic [3:0] fout);
      int ia, ib, sa, sb, s, sv, cin;
      logic [W-1:0] src;
      ia   = int'(fa);
      ib   = int'(fb);
      sa   = fa[W-1] ? ia - (1 << W) : ia;
      sb   = fb[W-1] ? ib - (1 << W) : ib;
      fout = fin;
      s    = 0;
      sv   = 0;
      res  = fa;
      case (op)
         AND_OP: begin res = fa & fb; fout[0] = 1'b0; end
         NOT_OP: begin res = ~fa;     fout[0] = 1'b0; end
         OR_OP:  begin res = fa | fb; fout[0] = 1'b0; end
         XOR_OP: begin res = fa ^ fb; fout[0] = 1'b0; end
         ADD_OP: begin
            cin = ch ? int'(fin[1]) : 0;
            s = ia + ib + cin;
            sv = sa + sb + cin;
            res = s[W-1:0];
            fout[1] = (s >= (1 << W));
         end
         SUB_OP, TST_OP: begin
            cin = ch ? int'(fin[1]) : 1;
            s = ia - ib - 1 + cin;
            sv = sa - sb - 1 + cin;
            res = (op == TST_OP) ? fa : s[W-1:0];
            fout[1] = (s >= 0);
         end
         default: res = fa;
      endcase
      if (op == ADD_OP || op == SUB_OP || op == TST_OP) begin
         fout[0] = (sv > (1 << (W-1)) - 1) || (sv < -(1 << (W-1)));
         src = s[W-1:0];
      end else begin
         src = res;
      end
      fout[3] = (src == '0);
      fout[2] = src[W-1];
   endfunction

   task automatic test_reset();
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", out_valid); end
      checks++; if (result !== 8'h00) begin errors++; $display("FAIL rst_result got %h exp 00", result); end
      checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL rst_flags got %b exp 0000", flags); end
      #10 rst_n = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", in_ready); end
      tick();
      out_ready = 1'b0;
      drive(1'b1, ADD_OP, 8'h80, 8'h80, 1'b0, 1'b0);
      tick();
      drive(1'b0, AND_OP, 8'h00, 8'h00, 1'b0, 1'b0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_pre_rst got %b exp 1", out_valid); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", out_valid); end
      checks++; if (result !== 8'h00) begin errors++; $display("FAIL midrst_result got %h exp 00", result); end
      checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL midrst_flags got %b exp 0000", flags); end
      #2 rst_n = 1'b1;
      out_ready = 1'b1;
      tick();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL postrst_ready got %b exp 1", in_ready); end
   endtask

   task automatic test_carry();
      drive(1'b1, ADD_OP, 8'hFF, 8'h01, 1'b0, 1'b0);
      tick();
      drive(1'b1, ADD_OP, 8'h00, 8'h00, 1'b1, 1'b0);
      checks++; if (result !== 8'h00) begin errors++; $display("FAIL carry_result got %h exp 00", result); end
      checks++; if (flags !== 4'b1010) begin errors++; $display("FAIL carry_flags got %b exp 1010", flags); end
      tick();
      drive(1'b0, AND_OP, 8'h00, 8'h00, 1'b0, 1'b0);
      checks++; if (result !== 8'h01) begin errors++; $display("FAIL chain_result got %h exp 01", result); end
      checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL chain_flags got %b exp 0000", flags); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %b exp 0", out_valid); end
   endtask

   task automatic test_overflow();
      drive(1'b1, SUB_OP, 8'h80, 8'h01, 1'b0, 1'b0);
      tick();
      drive(1'b1, SUB_OP, 8'h01, 8'h02, 1'b0, 1'b0);
      checks++; if (result !== 8'h7F) begin errors++; $display("FAIL ovf_result got %h exp 7f", result); end
      checks++; if (flags !== 4'b0011) begin errors++; $display("FAIL ovf_flags got %b exp 0011", flags); end
      tick();
      drive(1'b0, AND_OP, 8'h00, 8'h00, 1'b0, 1'b0);
      checks++; if (result !== 8'hFF) begin errors++; $display("FAIL borrow_result got %h exp ff", result); end
      checks++; if (flags !== 4'b0100) begin errors++; $display("FAIL borrow_flags got %b exp 0100", flags); end
      tick();
   endtask

   task automatic test_test_transfer();
      drive(1'b1, ADD_OP, 8'hFF, 8'h01, 1'b0, 1'b0);
      tick();
      drive(1'b1, TST_OP, 8'h05, 8'h05, 1'b0, 1'b0);
      tick();
      drive(1'b1, TRF_OP, 8'h00, 8'h5A, 1'b1, 1'b0);
      checks++; if (result !== 8'h05) begin errors++; $display("FAIL test_result got %h exp 05", result); end
      checks++; if (flags !== 4'b1010) begin errors++; $display("FAIL test_flags got %b exp 1010", flags); end
      tick();
      drive(1'b0, AND_OP, 8'h00, 8'h00, 1'b0, 1'b0);
      checks++; if (result !== 8'h00) begin errors++; $display("FAIL xfer_result got %h exp 00", result); end
      checks++; if (flags !== 4'b1010) begin errors++; $display("FAIL xfer_flags got %b exp 1010", flags); end
      tick();
   endtask

   task automatic test_stall();
      out_ready = 1'b0;
      drive(1'b1, XOR_OP, 8'h3C, 8'h0F, 1'b0, 1'b0);
      tick();
      drive(1'b1, AND_OP, 8'hF0, 8'hFF, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d] got %b exp 0", i, in_ready); end
         checks++; if (out_valid !== 1'b1 || result !== 8'h33) begin
            errors++; $display("FAIL stall_hold[%0d] got %b/%h exp 1/33", i, out_valid, result);
         end
         tick();
      end
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %b exp 1", in_ready); end
      tick();
      drive(1'b0, AND_OP, 8'h00, 8'h00, 1'b0, 1'b0);
      checks++; if (out_valid !== 1'b1 || result !== 8'hF0) begin
         errors++; $display("FAIL b2b_result got %b/%h exp 1/f0", out_valid, result);
      end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", out_valid); end
   endtask

   task automatic test_clear();
      drive(1'b1, SUB_OP, 8'h80, 8'h01, 1'b0, 1'b0);
      tick();
      drive(1'b1, OR_OP, 8'h00, 8'h00, 1'b0, 1'b1);
      checks++; if (flags !== 4'b0011) begin errors++; $display("FAIL clr_setup got %b exp 0011", flags); end
      tick();
      drive(1'b0, AND_OP, 8'h00, 8'h00, 1'b0, 1'b1);
      checks++; if (flags !== 4'b1010) begin errors++; $display("FAIL clr_collide got %b exp 1010", flags); end
      tick();
      drive(1'b0, AND_OP, 8'h00, 8'h00, 1'b0, 1'b0);
      checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL clr_alone got %b exp 0000", flags); end
      tick();
   endtask

   task automatic test_random();
      logic [W-1:0] exp_q[$];
      logic [3:0]   mf;
      logic         mready;
      logic [W-1:0] r;
      logic [3:0]   f;
      mf = 4'b0000;
      drive(1'b0, AND_OP, 8'h00, 8'h00, 1'b0, 1'b0);
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      tick();
      for (int i = 0; i < 500; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         a         = W'($urandom);
         b         = W'($urandom);
         select    = 3'($urandom);
         chain     = 1'($urandom);
         flags_clr = ($urandom_range(0, 7) == 0);
         #2;
         mready = (exp_q.size() == 0) || out_ready;
         checks++; if (in_ready !== mready) begin errors++; $display("FAIL rnd_ready[%0d] got %b exp %b", i, in_ready, mready); end
         checks++; if (out_valid !== (exp_q.size() != 0)) begin
            errors++; $display("FAIL rnd_valid[%0d] got %b exp %b", i, out_valid, exp_q.size() != 0);
         end
         if (exp_q.size() != 0) begin
            checks++; if (result !== exp_q[0]) begin errors++; $display("FAIL rnd_result[%0d] got %h exp %h", i, result, exp_q[0]); end
            if (out_ready) void'(exp_q.pop_front());
         end
         if (in_valid && mready) begin
            ref_op(a, b, select, chain, mf, r, f);
            mf = f;
            exp_q.push_back(r);
         end else if (flags_clr) begin
            mf = 4'b0000;
         end
         tick();
         checks++; if (flags !== mf) begin errors++; $display("FAIL rnd_flags[%0d] got %b exp %b", i, flags, mf); end
      end
      drive(1'b0, AND_OP, 8'h00, 8'h00, 1'b0, 1'b0);
      out_ready = 1'b1;
   endtask

   initial begin
      test_reset();
      test_carry();
      test_overflow();
      test_test_transfer();
      test_stall();
      test_clear();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
